// File: rtl/fsquare_iter_pkg.sv
// Shared single-precision constants, rounding-mode encodings and flag payload
// for the iterative FP squarer.
package fsquare_iter_pkg;

    localparam int unsigned ITER = 12;
    localparam int unsigned FW   = 32;
    localparam int unsigned MW   = 24;
    localparam int unsigned PW   = 48;
    localparam int unsigned EW   = 8;
    localparam int unsigned CW   = 5;

    localparam logic [FW-1:0] ZERO = 32'h0000_0000;
    localparam logic [FW-1:0] INF  = 32'h7f80_0000;
    localparam logic [FW-1:0] NAN  = 32'h7fc0_0000;
    localparam logic [FW-1:0] MAXF = 32'h7f7f_ffff;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_e;

    typedef struct packed {
        logic e00;
        logic eff;
        logic f00;
    } sflags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fsquare_round.sv
// Normalize, round and pack the 48-bit mantissa square; specials override.
module fsquare_round
    import fsquare_iter_pkg::*;
(
    input  logic [PW-1:0] p,
    input  logic [EW-1:0] exp_in,
    input  logic [1:0]    rm,
    input  sflags_t       flg,
    output logic [FW-1:0] s
);

    logic              hi;
    logic [22:0]       frac;
    logic [22:0]       frac_r;
    logic              guard;
    logic              sticky;
    logic              up;
    logic              carry;
    logic signed [9:0] exp_s;
    rm_e               rm_c;

    always_comb begin
        rm_c   = rm_e'(rm);
        hi     = p[47];
        frac   = hi ? p[46:24] : p[45:23];
        guard  = hi ? p[23] : p[22];
        sticky = hi ? |p[22:0] : |p[21:0];
        up     = 1'b0;
        unique case (rm_c)
            RM_RNE:  up = guard & (sticky | frac[0]);
            RM_RUP:  up = guard | sticky;
            default: up = 1'b0;
        endcase
        // A carry out of the fraction leaves frac_r at zero, i.e. 1.0 * 2^(E+1).
        {carry, frac_r} = {1'b0, frac} + 24'(up);
        exp_s = $signed({1'b0, exp_in, 1'b0}) - 10'sd127
              + $signed({9'b0, hi}) + $signed({9'b0, carry});

        s = {1'b0, exp_s[7:0], frac_r};
        if (exp_s >= 10'sd255) begin
            s = (rm_c == RM_RNE || rm_c == RM_RUP) ? INF : MAXF;
        end else if (exp_s <= 10'sd0) begin
            s = ZERO;
        end

        if (flg.eff) begin
            s = flg.f00 ? INF : NAN;
        end else if (flg.e00) begin
            s = ZERO;
        end
    end

endmodule

// File: rtl/fsquare_iter.sv
// Iterative single-precision squarer: radix-4 shift-add over 12 cycles with
// ID-stage stall handshake; result packed by fsquare_round.
module fsquare_iter
    import fsquare_iter_pkg::*;
(
    input  logic          clk,
    input  logic          clrn,
    input  logic [31:0]   d,
    input  logic [1:0]    rm,
    input  logic          fsquare,
    input  logic          ena,
    output logic [31:0]   s,
    output logic          busy,
    output logic          stall,
    output logic [4:0]    count
);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [MW-1:0]   m_q, m_d;
    logic [EW-1:0]   e_q, e_d;
    logic [1:0]      rm_q, rm_d;
    sflags_t         flg_q, flg_d;

    logic            start_c;
    logic            last_c;
    logic [5:0]      sh_c;
    logic [1:0]      dig_c;
    logic [PW-1:0]   pp_c;
    logic            unused_sign_c;

    assign unused_sign_c = d[31];
    assign last_c        = (count_q == CW'(ITER));
    assign start_c       = fsquare & ena & (state_q == ST_IDLE);

    // Partial product for digit k = count: m[2k-1:2k-2] * m << (2k-2).
    always_comb begin
        sh_c  = {count_q - 5'd1, 1'b0};
        dig_c = 2'(m_q >> sh_c);
        pp_c  = '0;
        unique case (dig_c)
            2'd0: pp_c = '0;
            2'd1: pp_c = PW'(m_q);
            2'd2: pp_c = PW'(m_q) << 1;
            2'd3: pp_c = PW'(m_q) + (PW'(m_q) << 1);
        endcase
        pp_c = pp_c << sh_c;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        m_d     = m_q;
        e_d     = e_q;
        rm_d    = rm_q;
        flg_d   = flg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    m_d       = {1'b1, d[22:0]};
                    e_d       = d[30:23];
                    rm_d      = rm;
                    flg_d.e00 = (d[30:23] == 8'h00);
                    flg_d.eff = (d[30:23] == 8'hff);
                    flg_d.f00 = (d[22:0] == 23'd0);
                    acc_d     = '0;
                    count_d   = 5'd1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_q + pp_c;
                if (last_c) begin
                    count_d = '0;
                    // Hold the result against a restart if the pipeline did not advance.
                    state_d = ena ? ST_IDLE : ST_DONE;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (ena) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            e_q     <= '0;
            rm_q    <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            e_q     <= e_d;
            rm_q    <= rm_d;
            flg_q   <= flg_d;
        end
    end

    assign busy  = (state_q == ST_BUSY);
    assign count = count_q;
    assign stall = (fsquare & (state_q == ST_IDLE)) | ((state_q == ST_BUSY) & ~last_c);

    fsquare_round u_round (
        .p      (acc_q),
        .exp_in (e_q),
        .rm     (rm_q),
        .flg    (flg_q),
        .s      (s)
    );

endmodule

// File: tb/tb_fsquare_iter.sv
// Self-checking bench for fsquare_iter: directed vectors, specials, handshake
// timing, mid-operation reset, held completion, and random operands vs a model.
module tb_fsquare_iter;

    logic        clk;
    logic        clrn;
    logic [31:0] d;
    logic [1:0]  rm;
    logic        fsquare;
    logic        ena;
    logic [31:0] s;
    logic        busy;
    logic        stall;
    logic [4:0]  count;

    int checks   = 0;
    int failures = 0;

    fsquare_iter dut (
        .clk     (clk),
        .clrn    (clrn),
        .d       (d),
        .rm      (rm),
        .fsquare (fsquare),
        .ena     (ena),
        .s       (s),
        .busy    (busy),
        .stall   (stall),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer square, then round by remainder vs half-ulp.
    function automatic logic [31:0] ref_square(input logic [31:0] x, input logic [1:0] r);
        longint unsigned m, p, q, rem, half;
        int              e, sh;
        bit              up;
        logic [7:0]      ex;
        logic [22:0]     fx;
        ex = x[30:23];
        fx = x[22:0];
        if (ex == 8'hff) return (fx != 23'd0) ? 32'h7fc00000 : 32'h7f800000;
        if (ex == 8'h00) return 32'h0;
        m    = 64'h80_0000 + 64'(fx);
        p    = m * m;
        sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
        e    = 2 * int'(ex) - 127 + ((sh == 24) ? 1 : 0);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        case (r)
            2'd0:    up = (rem > half) || (rem == half && q[0]);
            2'd2:    up = (rem != 0);
            default: up = 1'b0;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return (r == 2'd0 || r == 2'd2) ? 32'h7f800000 : 32'h7f7fffff;
        if (e <= 0) return 32'h0;
        return {1'b0, 8'(e), 23'(q)};
    endfunction

    // Issue one operation at a negedge; returns result at cycle 13 and stall length.
    task automatic run_op(input logic [31:0] dv, input logic [1:0] rmv,
                          output logic [31:0] res, output int nst);
        @(negedge clk);
        d = dv; rm = rmv; fsquare = 1'b1; ena = 1'b1;
        #1;
        nst = 0;
        while (stall === 1'b1 && nst < 40) begin
            nst++;
            @(negedge clk);
        end
        @(negedge clk);
        fsquare = 1'b0;
        #1;
        res = s;
    endtask

    task automatic test_reset();
        clrn = 1'b0; d = '0; rm = '0; fsquare = 1'b0; ena = 1'b0;
        #3;
        checks++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy);
        if (busy !== 1'b0) failures++;
        checks++; if (count !== 5'd0) begin $display("FAIL reset_count: got %0d want 0", count); failures++; end
        checks++; if (s !== 32'h0)    begin $display("FAIL reset_s: got %h want 00000000", s); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); failures++; end
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_timing();
        logic       eb, es;
        logic [4:0] ec;
        @(negedge clk);
        d = 32'h3f800000; rm = 2'd0; fsquare = 1'b1; ena = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            #1;
            eb = (c >= 1 && c <= 12);
            es = (c <= 11);
            ec = (c >= 1 && c <= 12) ? 5'(c) : 5'd0;
            checks++; if (busy !== eb)  begin $display("FAIL timing_busy c%0d: got %b want %b", c, busy, eb); failures++; end
            checks++; if (stall !== es) begin $display("FAIL timing_stall c%0d: got %b want %b", c, stall, es); failures++; end
            checks++; if (count !== ec) begin $display("FAIL timing_count c%0d: got %0d want %0d", c, count, ec); failures++; end
            if (c < 13) begin
                @(negedge clk);
                if (c == 12) fsquare = 1'b0;
            end
        end
        checks++; if (s !== 32'h3f800000) begin $display("FAIL timing_s: got %h want 3f800000", s); failures++; end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (s !== 32'h3f800000) begin $display("FAIL timing_s_held: got %h want 3f800000", s); failures++; end
    endtask

    task automatic test_directed();
        logic [31:0] dv [12] = '{32'h3fc00000, 32'hbf800000, 32'h3f800001, 32'h3f800001,
                                 32'h3f800001, 32'h5f800000, 32'h5f800000, 32'h1f800000,
                                 32'hff800000, 32'h7fc00001, 32'h80000000, 32'h00000001};
        logic [1:0]  rv [12] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0,
                                 2'd0, 2'd0, 2'd0, 2'd0};
        logic [31:0] ev [12] = '{32'h40100000, 32'h3f800000, 32'h3f800002, 32'h3f800003,
                                 32'h3f800002, 32'h7f800000, 32'h7f7fffff, 32'h00000000,
                                 32'h7f800000, 32'h7fc00000, 32'h00000000, 32'h00000000};
        logic [31:0] res;
        int          nst;
        for (int i = 0; i < 12; i++) begin
            run_op(dv[i], rv[i], res, nst);
            checks++;
            if (res !== ev[i]) begin
                $display("FAIL directed d=%h rm=%0d: got %h want %h", dv[i], rv[i], res, ev[i]);
                failures++;
            end
            checks++;
            if (nst != 12) begin
                $display("FAIL directed_stall d=%h: got %0d cycles want 12", dv[i], nst);
                failures++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          nst, n;
        @(negedge clk);
        d = 32'h3f800000; rm = 2'd0; fsquare = 1'b1; ena = 1'b1;
        n = 0;
        while (count !== 5'd5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 30) begin $display("FAIL reset_mid_wait: count never reached 5, got %0d", count); failures++; end
        clrn = 1'b0; fsquare = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)  begin $display("FAIL reset_mid_busy: got %b want 0", busy); failures++; end
        checks++; if (count !== 5'd0) begin $display("FAIL reset_mid_count: got %0d want 0", count); failures++; end
        checks++; if (s !== 32'h0)    begin $display("FAIL reset_mid_s: got %h want 00000000", s); failures++; end
        @(negedge clk);
        clrn = 1'b1;
        run_op(32'h40000000, 2'd0, res, nst);
        checks++; if (res !== 32'h40800000) begin $display("FAIL reset_mid_reissue: got %h want 40800000", res); failures++; end
        checks++; if (nst != 12) begin $display("FAIL reset_mid_stall: got %0d want 12", nst); failures++; end
    endtask

    task automatic test_hold_done();
        int n;
        @(negedge clk);
        d = 32'h3fc00000; rm = 2'd0; fsquare = 1'b1; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 40) begin $display("FAIL hold_wait: stall stuck, got %b want 0", stall); failures++; end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0)  begin $display("FAIL hold_busy: got %b want 0", busy); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL hold_stall: got %b want 0", stall); failures++; end
        checks++; if (s !== 32'h40100000) begin $display("FAIL hold_s: got %h want 40100000", s); failures++; end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || count !== 5'd0 || stall !== 1'b0) begin
            $display("FAIL hold_norestart: got busy=%b count=%0d stall=%b want 0/0/0", busy, count, stall);
            failures++;
        end
        ena = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0)  begin $display("FAIL hold_clear_busy: got %b want 0", busy); failures++; end
        checks++; if (stall !== 1'b1) begin $display("FAIL hold_clear_stall: got %b want 1", stall); failures++; end
        fsquare = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin $display("FAIL hold_idle: got %b want 0", busy); failures++; end
    endtask

    task automatic test_random();
        logic [31:0] dv, res, ev;
        logic [1:0]  rv;
        int          nst;
        for (int i = 0; i < 60; i++) begin
            dv = $urandom;
            if (i % 2 == 1) dv[30:23] = 8'($urandom_range(64, 190));
            rv = 2'($urandom_range(0, 3));
            ev = ref_square(dv, rv);
            run_op(dv, rv, res, nst);
            checks++;
            if (res !== ev) begin
                $display("FAIL random d=%h rm=%0d: got %h want %h", dv, rv, res, ev);
                failures++;
            end
            checks++;
            if (nst != 12) begin
                $display("FAIL random_stall d=%h: got %0d want 12", dv, nst);
                failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_directed();
        test_reset_mid();
        test_hold_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsquare_iter.md
Name: fsquare_iter

Overview:
- Single-precision FP squarer (s = d*d) for the FPU alongside the Newton square-root unit; computes the inverse operation of fsqrt.
- Same ID-stage issue/stall contract as the root unit: a multi-cycle radix-4 mantissa multiplier runs for a fixed 12 iterations, freezing the pipeline via `stall`.
- IEEE-754 packing with four rounding modes; underflow flushes to zero.

Parameters:
- ITER, 12, radix-4 iterations (24-bit mantissa / 2 bits); fixed, not for override.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- d  in  32  FP operand
- rm  in  2  round mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
- fsquare  in  1  ID-stage decode: fsquare instruction present
- ena  in  1  external pipeline advance; must not include this block's stall
- s  out  32  FP result
- busy  out  1  iteration in progress
- stall  out  1  pipeline stall request
- count  out  5  iteration counter

Behaviour:
- Reset: clrn, asynchronous, active-low; clock clk. On reset, busy=0, count=0, done=0, accumulator=0, all captured operand/rm/special flags=0, s=32'h00000000. Reset mid-operation aborts with no result.
- Start: start = fsquare & ~busy & ~done & ena. On the start edge:
  - capture m = {1,d[22:0]}, exponent, rm and special flags (e00, eff, f00);
  - clear the accumulator; busy<=1, count<=1.
- Iterate: while busy, each edge performs iteration k=count (1..12): acc += (m[2k-1:2k-2]*m) << (2k-2); count<=count+1. Iteration is independent of ena. After k=12, acc = m*m (48 bits).
- Complete: at the edge where busy & count==12: busy<=0, count<=0. done<=~ena, meaning done is set only if the pipeline did not advance on that edge. While done=1, any edge with ena=1 clears it. done blocks a re-start of the same held instruction.
- Stall: stall = (fsquare & ~busy & ~done) | (busy & count!=12), combinational.
  - For a start in cycle 0, stall is high in cycles 0..11 and low in cycle 12.
  - s is valid from cycle 13 and held until the next start edge.
- Result (combinational from registers): product sign is always 0.
  - P=acc. If P[47]: frac=P[46:24], guard=P[23], sticky=|P[22:0], eadj=1. Else frac=P[45:23], guard=P[22], sticky=|P[21:0], eadj=0.
  - Round up when: rm=00 and guard & (sticky | frac[0]); rm=10 and (guard | sticky); never for rm=01 or rm=11.
  - A rounding carry out of frac gives frac=0 and exponent+1.
  - E = 2*e_d - 127 + eadj + carry, 10-bit signed.
  - E>=255: rm 00 or 10 gives 7f800000; rm 01 or 11 gives 7f7fffff.
  - E<=0 gives 00000000 (flush-to-zero).
- Specials, which override the result and use the same 12-cycle latency:
  - NaN in gives 7fc00000;
  - +/-inf gives 7f800000;
  - +/-0 gives 00000000;
  - denormal gives 00000000;
  - input sign is ignored.
- fsquare deasserted mid-iteration has no effect; the operation completes.

Decomposition:
- Shared fp package: constants ZERO=32'h00000000, INF=32'h7f800000, NaN=32'h7fc00000, MAXF=32'h7f7fffff; rm encodings RM_RNE, RM_RDN, RM_RUP, RM_RTZ.
- One sub-module fsquare_round: combinational normalize/round/pack/special-case selection from {P, e_d, rm, flags}.
- Counter, accumulator and handshake logic stay in fsquare_iter.

Test Plan:
- d=3f800000, rm=00, ena=1, fsquare pulse held until release → stall high exactly 12 cycles, busy high cycles 1..12, s=3f800000 from cycle 13.
- d=3fc00000 → 40100000. d=bf800000 → 3f800000.
- d=3f800001: rm=00 → 3f800002; rm=10 → 3f800003; rm=11 → 3f800002.
- d=5f800000: rm=00 → 7f800000; rm=11 → 7f7fffff. d=1f800000 → 00000000.
- Specials: d=ff800000 → 7f800000; 7fc00001 → 7fc00000; 80000000 → 00000000; 00000001 → 00000000; each with 12-cycle stall.
- Assert clrn low at count=5 → busy=0, count=0, s=0 immediately; re-issue d=40000000 → 40800000.
- Hold ena=0 across completion with fsquare still high → done=1, no restart, stall=0; raising ena clears done.
